// File: rtl/sequenciador_frota.sv
// sequenciador_frota
// Fleet-placement sequencer for the Batalha Naval board. Walks the placement
// datapath through each player's fleet in fixed order (submarino, cruzador,
// hidroaviao, encouracado, porta-avioes), presenting the current piece type,
// the count already stored for that type and the active player. In
// Player1 x CPU mode the second fleet is handed to the CPU placer through
// cpu_req. Once both fleets are complete, ready is raised.
//
// Optional feature: define FROTA_WATCHDOG_EN to add a CPU watchdog. While the
// CPU placer owns the board, a 10-bit counter measures cycles since the last
// stored piece. On reaching TIMEOUT_CICLOS it pulses erro_cpu and aborts to
// IDLE. Without the macro, erro_cpu is tied low.
module sequenciador_frota #(
  parameter int unsigned QTD_SUB        = 5,
  parameter int unsigned QTD_CRUZ       = 2,
  parameter int unsigned QTD_HIDRO      = 2,
  parameter int unsigned QTD_ENC        = 1,
  parameter int unsigned QTD_PORTA      = 1,
  parameter int unsigned TIMEOUT_CICLOS = 1023
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       mode,
  input  logic       armazena,
  output logic [2:0] tipo,
  output logic [2:0] qtd_tipo,
  output logic       jogador,
  output logic       cpu_req,
  output logic       ready,
  output logic [5:0] pecas_restantes,
  output logic       erro_cpu
);

  localparam int unsigned TOTAL_INT = QTD_SUB + QTD_CRUZ + QTD_HIDRO + QTD_ENC + QTD_PORTA;
  localparam logic [5:0]  TOTAL     = 6'(TOTAL_INT);
  localparam logic [2:0]  TIPO_ULT  = 3'd4;

  // Elaboration-time legality checks on the configuration
  if (QTD_SUB < 1 || QTD_SUB > 7 || QTD_CRUZ < 1 || QTD_CRUZ > 7 ||
      QTD_HIDRO < 1 || QTD_HIDRO > 7 || QTD_ENC < 1 || QTD_ENC > 7 ||
      QTD_PORTA < 1 || QTD_PORTA > 7) begin : g_bad_qtd
    $error("sequenciador_frota: QTD_* parameters must be in 1..7");
  end
  if (TIMEOUT_CICLOS < 1 || TIMEOUT_CICLOS > 1023) begin : g_bad_timeout
    $error("sequenciador_frota: TIMEOUT_CICLOS must be in 1..1023");
  end

  typedef enum logic [2:0] {
    IDLE,
    COLOCA_J0,
    COLOCA_J1,
    COLOCA_CPU,
    PRONTO
  } estado_t;

  estado_t    state_q;
  logic [2:0] tipo_q;
  logic [2:0] qtd_q;
  logic       jogador_q;
  logic       cpu_req_q;
  logic       ready_q;
  logic [5:0] pecas_q;
  logic       armazena_q;
  logic       mode_l_q;
  logic       ev;
  logic       timeout_w;
  logic [3:0] qtd_prox;
  logic [3:0] quota_atual;

  // Quota of pieces for a given type
  function automatic logic [2:0] quota(input logic [2:0] t);
    logic [2:0] q;
    case (t)
      3'd0:    q = 3'(QTD_SUB);
      3'd1:    q = 3'(QTD_CRUZ);
      3'd2:    q = 3'(QTD_HIDRO);
      3'd3:    q = 3'(QTD_ENC);
      default: q = 3'(QTD_PORTA);
    endcase
    return q;
  endfunction

  // Rising-edge detect on armazena, plus the comparison operands for the counting step
  always_comb begin
    ev          = armazena & ~armazena_q;
    qtd_prox    = {1'b0, qtd_q} + 4'd1;
    quota_atual = {1'b0, quota(tipo_q)};
  end

`ifdef FROTA_WATCHDOG_EN
  logic [9:0] wdog_q;
  logic       erro_q;

  // Cycles since the last stored piece while the CPU placer owns the board
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wdog_q <= '0;
    end else if (state_q != COLOCA_CPU || ev || timeout_w) begin
      wdog_q <= '0;
    end else begin
      wdog_q <= wdog_q + 10'd1;
    end
  end

  // Expiry on the edge that would bring the counter up to the limit
  always_comb begin
    timeout_w = (state_q == COLOCA_CPU) && !ev &&
                (wdog_q == 10'(TIMEOUT_CICLOS - 1));
  end

  // One-cycle error pulse on expiry; enable low wins over the watchdog
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      erro_q <= 1'b0;
    end else begin
      erro_q <= timeout_w & enable;
    end
  end

  assign erro_cpu = erro_q;
`else
  // Without the watchdog nothing can time out
  always_comb begin
    timeout_w = 1'b0;
  end

  assign erro_cpu = 1'b0;
`endif

  // Main sequencer: state, counters and all registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      tipo_q     <= '0;
      qtd_q      <= '0;
      jogador_q  <= 1'b0;
      cpu_req_q  <= 1'b0;
      ready_q    <= 1'b0;
      pecas_q    <= TOTAL;
      armazena_q <= 1'b0;
      mode_l_q   <= 1'b0;
    end else begin
      armazena_q <= armazena;
      if (!enable || timeout_w) begin
        // Synchronous abort: everything but the edge detector returns to reset values
        state_q   <= IDLE;
        tipo_q    <= '0;
        qtd_q     <= '0;
        jogador_q <= 1'b0;
        cpu_req_q <= 1'b0;
        ready_q   <= 1'b0;
        pecas_q   <= TOTAL;
        mode_l_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            mode_l_q <= mode;
            state_q  <= COLOCA_J0;
          end
          COLOCA_J0, COLOCA_J1, COLOCA_CPU: begin
            if (ev) begin
              if (qtd_prox < quota_atual) begin
                qtd_q   <= qtd_q + 3'd1;
                pecas_q <= pecas_q - 6'd1;
              end else if (tipo_q != TIPO_ULT) begin
                qtd_q   <= '0;
                tipo_q  <= tipo_q + 3'd1;
                pecas_q <= pecas_q - 6'd1;
              end else begin
                // Last piece of the fleet: rewind the type walk and move on
                tipo_q    <= '0;
                qtd_q     <= '0;
                jogador_q <= 1'b1;
                if (state_q == COLOCA_J0) begin
                  pecas_q <= TOTAL;
                  if (mode_l_q) begin
                    state_q <= COLOCA_J1;
                  end else begin
                    state_q   <= COLOCA_CPU;
                    cpu_req_q <= 1'b1;
                  end
                end else begin
                  pecas_q   <= '0;
                  state_q   <= PRONTO;
                  cpu_req_q <= 1'b0;
                  ready_q   <= 1'b1;
                end
              end
            end
          end
          PRONTO: begin
            ready_q <= 1'b1;
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign tipo            = tipo_q;
  assign qtd_tipo        = qtd_q;
  assign jogador         = jogador_q;
  assign cpu_req         = cpu_req_q;
  assign ready           = ready_q;
  assign pecas_restantes = pecas_q;

endmodule

// File: doc/sequenciador_frota.md
Name: sequenciador_frota

Overview:
- Fleet-placement sequencer for the Batalha Naval board.
- Sequences the piece-placement datapath through the fleet of each player in fixed order: submarino, cruzador, hidroaviao, encouracado, porta-avioes.
- Drives the current piece type, per-type count and active player to the placement datapath and the validator.
- Hands player 1's fleet to the CPU placer in P1 x CPU mode, then raises ready to start the game.

Parameters:
- QTD_SUB, 5, submarinos per fleet (tipo 0)
- QTD_CRUZ, 2, cruzadores per fleet (tipo 1)
- QTD_HIDRO, 2, hidroavioes per fleet (tipo 2)
- QTD_ENC, 1, encouracados per fleet (tipo 3)
- QTD_PORTA, 1, porta-avioes per fleet (tipo 4)
- TIMEOUT_CICLOS, 1023, CPU watchdog limit; used only with the optional feature
- All QTD_* parameters are in the range 1..7.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- enable  in  1  1 = sequencing allowed; 0 = abort to IDLE
- mode  in  1  0 = Player1 x CPU, 1 = Player1 x Player2
- armazena  in  1  piece stored without conflict, from the placement datapath or CPU placer; rising edge counts
- tipo  out  3  current piece type, 0..4
- qtd_tipo  out  3  pieces of the current type already stored
- jogador  out  1  board/memory being filled, 0 or 1
- cpu_req  out  1  CPU placer must fill player 1's fleet
- ready  out  1  both fleets complete; game may start
- pecas_restantes  out  6  pieces still to place for the current jogador
- erro_cpu  out  1  CPU watchdog expired (tied 0 without the optional feature)

Behaviour:
- Reset (async, reset=0) values:
  - state=IDLE, tipo=0, qtd_tipo=0, jogador=0, cpu_req=0, ready=0, erro_cpu=0
  - pecas_restantes=TOTAL, where TOTAL = sum of the QTD_* parameters (11 at defaults)
  - internal armazena_d=0, mode_l=0
- Event detection: ev = armazena & ~armazena_d. armazena_d is registered every clk.
  - ev is used in the same cycle, so counters update on the edge where armazena is first sampled high.
  - Holding armazena high counts once.
- States and transitions:
  - IDLE: when enable=1, latch mode_l=mode and go to COLOCA_J0. mode changes after this point are ignored.
  - COLOCA_J0 (jogador=0): on ev:
    - If qtd_tipo+1 < quota(tipo): qtd_tipo++.
    - Otherwise: qtd_tipo=0, tipo++.
    - pecas_restantes-- on every ev.
  - End of fleet: ev on tipo=4 with the last piece. Then tipo=0, qtd_tipo=0, pecas_restantes=TOTAL, jogador=1, and:
    - mode_l=1: go to COLOCA_J1.
    - mode_l=0: go to COLOCA_CPU with cpu_req=1.
  - COLOCA_J1 and COLOCA_CPU: same counting as COLOCA_J0.
    - cpu_req stays 1 for the whole of COLOCA_CPU and drops to 0 on the edge that leaves it.
    - End of fleet: go to PRONTO; pecas_restantes=0.
  - PRONTO: ready=1, held. tipo=0, qtd_tipo=0, jogador=1.
- Boundary conditions:
  - ev in IDLE or PRONTO is ignored; armazena_d still updates.
  - enable=0 in any state: on the next clk edge, synchronously return to all reset values except armazena_d. This takes priority over a simultaneous ev.
  - enable held 1 while in PRONTO does not restart; a restart needs enable low then high.
  - reset mid-placement: immediate async clear; no partial fleet is retained.
  - tipo never exceeds 4; qtd_tipo never reaches quota(tipo).
- All outputs are registered; no combinational path from inputs to outputs.

Optional Feature:
- Macro FROTA_WATCHDOG_EN.
- Defined:
  - A 10-bit counter runs in COLOCA_CPU; it is cleared on every ev and on state entry.
  - When it reaches TIMEOUT_CICLOS: erro_cpu=1 for one cycle, cpu_req=0, state goes to IDLE, and counts clear as for enable=0.
- Undefined: no counter; erro_cpu is constant 0.

Test Plan:
- Reset, then enable=1, mode=1, then 11 armazena pulses (1 cycle high, 2 low) -> tipo steps 0,0,0,0,0,1,1,2,2,3,4; then jogador=1, tipo=0, pecas_restantes=11. A further 11 pulses -> ready=1, pecas_restantes=0.
- mode=0 with 11 pulses -> cpu_req=1 and jogador=1 on the edge after the 11th ev. After 11 more pulses -> cpu_req=0 and ready=1 on the same edge.
- armazena held high for 10 cycles in COLOCA_J0 -> qtd_tipo=1 only, pecas_restantes=10.
- After 7 pulses, deassert enable -> next edge all outputs return to reset values. Re-enable -> tipo=0, qtd_tipo=0.
- Toggle mode after leaving IDLE with mode=1, then finish J0 -> COLOCA_J1 entered and cpu_req stays 0.
- With FROTA_WATCHDOG_EN and TIMEOUT_CICLOS=20: enter COLOCA_CPU, give no pulses -> erro_cpu pulses on cycle 20, state returns to IDLE, cpu_req=0.
